// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for a single-ALU RISC-V datapath
module multicycle_ctrl #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          imem_rdata,
    input  logic                 imem_ready,
    output logic                 imem_req,
    output logic [31:0]          ir,
    input  logic                 Zero,
    input  logic                 dmem_ready,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 PCSrc,
    output logic                 ALUSrc,
    output logic [1:0]           ImmSel,
    output logic [3:0]           ALUCtrl,
    output logic                 RegWrite,
    output logic                 MemToReg,
    output logic                 loadPC,
    output logic                 retire,
    output logic [INSTRET_W-1:0] instret,
    output logic                 illegal
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    state_t                r_state, w_next;
    logic [31:0]           r_ir;
    logic [INSTRET_W-1:0]  r_instret;
    logic                  r_illegal;
    logic [6:0]            w_opc, w_f7;
    logic [2:0]            w_f3;
    logic                  w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_beq, w_legal, w_alt, w_dec;
    logic [3:0]            w_arith;
    assign w_opc    = r_ir[6:0];
    assign w_f3     = r_ir[14:12];
    assign w_f7     = r_ir[31:25];
    assign w_is_r   = (w_opc == 7'b0110011) &&
                      ((w_f7 == 7'b0000000 && w_f3 != 3'b011) ||
                       (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
    assign w_is_i   = (w_opc == 7'b0010011) &&
                      ((w_f3 == 3'b001) ? (w_f7 == 7'b0000000) :
                       (w_f3 == 3'b101) ? (w_f7 == 7'b0000000 || w_f7 == 7'b0100000) :
                                          (w_f3 != 3'b011));
    assign w_is_lw  = (w_opc == 7'b0000011) && (w_f3 == 3'b010);
    assign w_is_sw  = (w_opc == 7'b0100011) && (w_f3 == 3'b010);
    assign w_is_beq = (w_opc == 7'b1100011) && (w_f3 == 3'b000);
    assign w_legal  = w_is_r || w_is_i || w_is_lw || w_is_sw || w_is_beq;
    // bit 30 selects sub/sra only where it is an opcode bit, never an addi immediate bit
    assign w_alt    = r_ir[30] && (w_is_r || (w_is_i && w_f3 == 3'b101));
    assign w_dec    = (r_state == S_DECODE) || (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);
    assign ir       = r_ir;
    assign instret  = r_instret;
    assign illegal  = r_illegal;

    // ALU operation for register/immediate arithmetic, selected by funct3
    always_comb begin
        case (w_f3)
            3'b000:  w_arith = w_alt ? 4'b0110 : 4'b0010;
            3'b001:  w_arith = 4'b1001;
            3'b010:  w_arith = 4'b0111;
            3'b100:  w_arith = 4'b1101;
            3'b101:  w_arith = w_alt ? 4'b1010 : 4'b1000;
            3'b110:  w_arith = 4'b0001;
            3'b111:  w_arith = 4'b0000;
            default: w_arith = 4'b0010;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    // next-state sequencing; FETCH and MEM wait on their ready without timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = imem_ready ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
            S_EXEC:   w_next = w_is_beq ? S_FETCH : (w_is_lw || w_is_sw) ? S_MEM : S_WB;
            S_MEM:    w_next = !dmem_ready ? S_MEM : w_is_lw ? S_WB : S_FETCH;
            S_WB:     w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_FETCH;
        endcase
    end

    // control strobes; reset masks every strobe so an abandoned access has no effect
    always_comb begin
        imem_req = !rst && (r_state == S_FETCH);
        MemRead  = !rst && (r_state == S_MEM) && w_is_lw;
        MemWrite = !rst && (r_state == S_MEM) && w_is_sw;
        loadPC   = !rst && (((r_state == S_EXEC) && w_is_beq) ||
                            ((r_state == S_MEM) && w_is_sw && dmem_ready) ||
                            (r_state == S_WB));
        retire   = loadPC;
        PCSrc    = !rst && (r_state == S_EXEC) && w_is_beq && Zero;
        RegWrite = !rst && (r_state == S_WB) && (r_ir[11:7] != 5'd0);
        MemToReg = (r_state == S_WB) && w_is_lw;
        ALUSrc   = w_dec && (w_is_i || w_is_lw || w_is_sw);
        ImmSel   = !w_dec ? 2'b00 : w_is_sw ? 2'b01 : w_is_beq ? 2'b10 : 2'b00;
        ALUCtrl  = !w_dec ? 4'b0000 :
                   (w_is_r || w_is_i) ? w_arith :
                   w_is_beq ? 4'b0110 :
                   (w_is_lw || w_is_sw) ? 4'b0010 : 4'b0000;
    end

    // instruction register, retired counter and sticky trap flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir      <= 32'd0;
            r_instret <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (r_state == S_FETCH && imem_ready) r_ir <= imem_rdata;
            if (retire) r_instret <= r_instret + INSTRET_W'(1);
            if (r_state == S_DECODE && !w_legal) r_illegal <= 1'b1;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream checked against a per-instruction reference model
module tb_multicycle_ctrl;
    localparam int IW = 4;
    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   imem_rdata;
    logic          imem_ready, imem_req;
    logic [31:0]   ir;
    logic          Zero, dmem_ready, MemRead, MemWrite, PCSrc, ALUSrc;
    logic [1:0]    ImmSel;
    logic [3:0]    ALUCtrl;
    logic          RegWrite, MemToReg, loadPC, retire;
    logic [IW-1:0] instret;
    logic          illegal;
    int            checks = 0;
    int            errors = 0;
    int            exp_ret = 0;

    // {opcode, funct3, funct7, funct7-is-immediate, class, ALU op}; class 1 R, 2 I, 3 lw, 4 sw, 5 beq
    localparam logic [24:0] OPS [20] = '{
        {7'b0110011, 3'b000, 7'h00, 1'b0, 3'd1, 4'b0010},
        {7'b0110011, 3'b000, 7'h20, 1'b0, 3'd1, 4'b0110},
        {7'b0110011, 3'b001, 7'h00, 1'b0, 3'd1, 4'b1001},
        {7'b0110011, 3'b010, 7'h00, 1'b0, 3'd1, 4'b0111},
        {7'b0110011, 3'b100, 7'h00, 1'b0, 3'd1, 4'b1101},
        {7'b0110011, 3'b101, 7'h00, 1'b0, 3'd1, 4'b1000},
        {7'b0110011, 3'b101, 7'h20, 1'b0, 3'd1, 4'b1010},
        {7'b0110011, 3'b110, 7'h00, 1'b0, 3'd1, 4'b0001},
        {7'b0110011, 3'b111, 7'h00, 1'b0, 3'd1, 4'b0000},
        {7'b0010011, 3'b000, 7'h00, 1'b1, 3'd2, 4'b0010},
        {7'b0010011, 3'b010, 7'h00, 1'b1, 3'd2, 4'b0111},
        {7'b0010011, 3'b100, 7'h00, 1'b1, 3'd2, 4'b1101},
        {7'b0010011, 3'b110, 7'h00, 1'b1, 3'd2, 4'b0001},
        {7'b0010011, 3'b111, 7'h00, 1'b1, 3'd2, 4'b0000},
        {7'b0010011, 3'b001, 7'h00, 1'b0, 3'd2, 4'b1001},
        {7'b0010011, 3'b101, 7'h00, 1'b0, 3'd2, 4'b1000},
        {7'b0010011, 3'b101, 7'h20, 1'b0, 3'd2, 4'b1010},
        {7'b0000011, 3'b010, 7'h00, 1'b1, 3'd3, 4'b0010},
        {7'b0100011, 3'b010, 7'h00, 1'b1, 3'd4, 4'b0010},
        {7'b1100011, 3'b000, 7'h00, 1'b1, 3'd5, 4'b0110}
    };

    multicycle_ctrl #(.INSTRET_W(IW)) dut (
        .clk(clk), .rst(rst), .imem_rdata(imem_rdata), .imem_ready(imem_ready), .imem_req(imem_req),
        .ir(ir), .Zero(Zero), .dmem_ready(dmem_ready), .MemRead(MemRead), .MemWrite(MemWrite),
        .PCSrc(PCSrc), .ALUSrc(ALUSrc), .ImmSel(ImmSel), .ALUCtrl(ALUCtrl), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .loadPC(loadPC), .retire(retire), .instret(instret), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // runs one legal instruction from its first FETCH cycle; called at posedge+1 with the DUT in FETCH
    task automatic run_instr(input logic [31:0] instr, input int cls, input logic [3:0] alu,
                             input int iw, input int dw, input bit z);
        int n = 0, reqs = 0, mems = 0, nrd = 0, nwr = 0, nrw = 0, nld = 0, nret = 0, ctl_bad = 0, ld_bad = 0;
        bit done = 0, ld_pc = 0, m2r = 0;
        bit src = (cls == 2 || cls == 3 || cls == 4);
        logic [1:0] isel = (cls == 4) ? 2'b01 : (cls == 5) ? 2'b10 : 2'b00;
        int lat = ((cls == 5) ? 3 : (cls == 3) ? 5 : 4) + iw + ((cls == 3 || cls == 4) ? dw : 0);
        bit writes_rd = (cls <= 3) && (instr[11:7] != 5'd0);
        imem_rdata = instr;
        Zero = z;
        while (!done && n < 200) begin
            imem_ready = (reqs == iw);
            dmem_ready = (mems == dw);
            @(negedge clk);
            n++;
            if (imem_req) reqs++;
            if (MemRead || MemWrite) mems++;
            nrd += int'(MemRead);
            nwr += int'(MemWrite);
            nrw += int'(RegWrite);
            nret += int'(retire);
            if (!imem_req && (ALUCtrl !== alu || ALUSrc !== src || (cls != 1 && ImmSel !== isel))) ctl_bad++;
            if (loadPC) begin
                nld++;
                ld_pc = PCSrc;
                if (!retire) ld_bad++;
            end
            if (retire) begin
                done = 1;
                m2r = MemToReg;
            end
            @(posedge clk);
            #1;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        exp_ret = (exp_ret + 1) % (1 << IW);
        check("done", 32'(done), 32'd1);
        check("latency", n, lat);
        check("memread_cycles", nrd, (cls == 3) ? dw + 1 : 0);
        check("memwrite_cycles", nwr, (cls == 4) ? dw + 1 : 0);
        check("regwrite_cycles", nrw, writes_rd ? 1 : 0);
        check("loadpc_count", nld, 1);
        check("loadpc_not_final", ld_bad, 0);
        check("retire_count", nret, 1);
        check("pcsrc", 32'(ld_pc), (cls == 5) ? 32'(z) : 32'd0);
        check("ctl_stable", ctl_bad, 0);
        if (cls <= 3) check("memtoreg", 32'(m2r), 32'(cls == 3));
        check("instret", 32'(instret), exp_ret);
        check("ir", ir, instr);
    endtask

    // fetches an unsupported word, watches the trap, then leaves it through reset
    task automatic run_illegal(input logic [31:0] instr, input int iw);
        int n = 0, reqs = 0, bad = 0;
        bit fetched = 0;
        imem_rdata = instr;
        dmem_ready = 1'b0;
        while (!fetched && n < 50) begin
            imem_ready = (reqs == iw);
            @(negedge clk);
            n++;
            if (imem_req) begin
                reqs++;
                if (imem_ready) fetched = 1;
            end
            @(posedge clk);
            #1;
        end
        check("trap_fetched", 32'(fetched), 32'd1);
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        repeat (22) begin
            @(negedge clk);
            bad += int'(imem_req || MemRead || MemWrite || RegWrite || loadPC || retire);
        end
        check("trap_quiet", bad, 0);
        check("trap_flag", 32'(illegal), 32'd1);
        check("trap_instret", 32'(instret), exp_ret);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        exp_ret = 0;
        @(negedge clk);
        check("trap_cleared", 32'(illegal), 32'd0);
        check("trap_refetch", 32'(imem_req), 32'd1);
        check("trap_ir", ir, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // abandons a stalled lw with reset while MemRead is high
    task automatic reset_in_mem;
        int n = 0, nrd = 0;
        imem_rdata = 32'h0080A283;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        while (nrd < 3 && n < 20) begin
            @(negedge clk);
            n++;
            nrd += int'(MemRead);
            @(posedge clk);
            #1;
        end
        check("mem_stalled", nrd, 3);
        imem_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_memread", 32'(MemRead), 32'd0);
        check("rst_regwrite", 32'(RegWrite), 32'd0);
        check("rst_loadpc", 32'(loadPC | retire), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ret = 0;
        @(negedge clk);
        check("post_rst_fetch", 32'(imem_req), 32'd1);
        check("post_rst_ir", ir, 32'd0);
        check("post_rst_instret", 32'(instret), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [24:0] e;
        logic [6:0]  opc, f7, o;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic [31:0] w;
        bit          free;
        int          cls;
        rst = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        Zero = 1'b0;
        imem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_imem_req", 32'(imem_req), 32'd0);
        check("reset_strobes", {26'd0, MemRead, MemWrite, RegWrite, loadPC, retire, PCSrc}, 32'd0);
        check("reset_ir", ir, 32'd0);
        check("reset_instret", 32'(instret), 32'd0);
        check("reset_illegal", 32'(illegal), 32'd0);
        rst = 1'b0;
        run_instr(32'h002081B3, 1, 4'b0010, 0, 0, 1'b0);
        run_instr(32'h0080A283, 3, 4'b0010, 0, 3, 1'b0);
        run_instr(32'h0050A623, 4, 4'b0010, 0, 0, 1'b0);
        run_instr(32'h00208463, 5, 4'b0110, 0, 0, 1'b1);
        run_instr(32'h00208463, 5, 4'b0110, 0, 0, 1'b0);
        run_instr(32'h00000013, 2, 4'b0010, 2, 0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                w = $urandom;
                case ($urandom_range(0, 7))
                    0: begin
                        do o = 7'($urandom); while (o inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011});
                        w[6:0] = o;
                    end
                    1: w = {7'h00, w[24:15], 3'b011, w[11:7], 7'b0110011};
                    2: w = {7'h01, w[24:15], 3'b000, w[11:7], 7'b0110011};
                    3: w = {w[31:15], 3'b000, w[11:7], 7'b0000011};
                    4: w = {w[31:15], 3'b001, w[11:7], 7'b0100011};
                    5: w = {w[31:15], 3'b001, w[11:7], 7'b1100011};
                    6: w = {7'h20, w[24:15], 3'b001, w[11:7], 7'b0010011};
                    default: w = {w[31:15], 3'b011, w[11:7], 7'b0010011};
                endcase
                run_illegal(w, $urandom_range(0, 2));
            end else begin
                e = OPS[$urandom_range(0, 19)];
                {opc, f3, f7, free, cls, alu} = {e[24:18], e[17:15], e[14:8], e[7], 32'(e[6:4]), e[3:0]};
                w = $urandom;
                w = {free ? w[31:25] : f7, w[24:15], f3, ($urandom_range(0, 7) == 0) ? 5'd0 : w[11:7], opc};
                run_instr(w, cls, alu, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
            end
        end
        run_illegal(32'hFFFFFFFF, 1);
        run_instr(32'h002081B3, 1, 4'b0010, 0, 0, 1'b0);
        run_instr(32'h40A3D213, 2, 4'b1010, 1, 0, 1'b0);
        reset_in_mem();
        run_instr(32'h0050A623, 4, 4'b0010, 0, 1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
